// File: rtl/multicycle_mem_responder.sv
// rtl/multicycle_mem_responder.sv - unified instruction/data memory responder with fixed LATENCY
// Accepts one request at a time and pulses mem_ready LATENCY cycles after acceptance.
module multicycle_mem_responder #(
  parameter int DATA_W    = 19,
  parameter int ADDR_W    = 13,
  parameter int DEPTH     = 8192,
  parameter int LATENCY   = 2,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_read,
  input  logic              MEM_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W      = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int CNT_INIT_I = (LATENCY >= 2) ? LATENCY - 2 : 0;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(CNT_INIT_I);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic                conflict_q, conflict_d;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                enter_resp;
  logic                in_range;
  logic [IDX_W-1:0]    idx;

  logic [DATA_W-1:0]   mem_q [0:DEPTH-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    conflict_d = conflict_q;
    case (state_q)
      S_IDLE: begin
        if (MEM_read || MEM_write) begin
          addr_d     = mem_addr;
          wdata_d    = mem_wdata;
          wr_d       = MEM_write;
          conflict_d = MEM_read & MEM_write;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The *_d transaction fields equal the live inputs on an accepting IDLE edge
  // and the latched copy otherwise, so LATENCY==1 needs no special access path.
  assign enter_resp = (state_d == S_RESP);
  assign in_range   = ({1'b0, addr_d} < DEPTH_L);
  assign idx        = addr_d[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      conflict_q <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      conflict_q <= conflict_d;
      if (enter_resp) begin
        err_q <= !in_range || conflict_d;
        if (!wr_d) rdata_q <= in_range ? mem_q[idx] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enter_resp && wr_d && in_range) mem_q[idx] <= wdata_d;
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = (state_q == S_RESP);
  assign mem_busy  = (state_q != S_IDLE);
  assign mem_err   = mem_ready & err_q;

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// tb/tb_multicycle_mem_responder.sv - self-checking bench for multicycle_mem_responder
// Directed steps plus randomized transactions against a small array model.
module tb_multicycle_mem_responder;

  localparam int DATA_W = 19;
  localparam int ADDR_W = 13;
  localparam int DEPTH  = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              MEM_read, MEM_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready, mem_busy, mem_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mem_m [0:15];
  logic [DATA_W-1:0] last_rd;

  multicycle_mem_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(2), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .MEM_read(MEM_read), .MEM_write(MEM_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_busy(mem_busy), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction: request at t0, ready expected in the second cycle after.
  task automatic txn(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input string tag);
    logic oob;
    logic exp_err;
    oob     = (a >= DEPTH);
    exp_err = oob | (rd & wr);
    if (wr) begin
      if (!oob) mem_m[a[3:0]] = d;
    end else begin
      last_rd = oob ? '0 : mem_m[a[3:0]];
    end
    @(negedge clk);
    MEM_read = rd; MEM_write = wr; mem_addr = a; mem_wdata = d;
    @(negedge clk);
    check({tag, " busy_wait"}, mem_busy, 1);
    check({tag, " ready_wait"}, mem_ready, 0);
    MEM_read = 1'b0; MEM_write = 1'b0;
    mem_addr = ADDR_W'($urandom); mem_wdata = DATA_W'($urandom);
    @(negedge clk);
    check({tag, " ready"}, mem_ready, 1);
    check({tag, " busy_resp"}, mem_busy, 1);
    check({tag, " err"}, mem_err, exp_err);
    check({tag, " rdata"}, mem_rdata, last_rd);
    @(negedge clk);
    check({tag, " ready_after"}, mem_ready, 0);
    check({tag, " busy_after"}, mem_busy, 0);
    check({tag, " err_after"}, mem_err, 0);
    check({tag, " rdata_hold"}, mem_rdata, last_rd);
  endtask

  initial begin
    rst = 1'b1; MEM_read = 1'b0; MEM_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    last_rd = '0;
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset rdata", mem_rdata, 0);
    check("reset ready", mem_ready, 0);
    check("reset busy", mem_busy, 0);
    check("reset err", mem_err, 0);

    txn(1'b0, 1'b1, 13'd5, 19'h1ABCD, "t1 write5");
    txn(1'b1, 1'b0, 13'd5, 19'h0, "t2 read5");
    repeat (3) @(negedge clk);
    check("t2 idle hold", mem_rdata, 19'h1ABCD);

    // Request held across the response is re-accepted three edges later.
    @(negedge clk);
    MEM_read = 1'b1; mem_addr = 13'd5;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("t3 ready s%0d", k), mem_ready, (k == 2 || k == 5) ? 1 : 0);
      if (k == 2 || k == 5) begin
        check($sformatf("t3 rdata s%0d", k), mem_rdata, 19'h1ABCD);
        check($sformatf("t3 err s%0d", k), mem_err, 0);
      end
      if (k == 4) MEM_read = 1'b0;
    end
    last_rd = 19'h1ABCD;

    txn(1'b1, 1'b1, 13'd7, 19'h00042, "t4 conflict7");
    txn(1'b1, 1'b0, 13'd7, 19'h0, "t4 read7");

    for (int i = 0; i < 16; i++) txn(1'b0, 1'b1, ADDR_W'(i), DATA_W'($urandom), "prewrite");

    txn(1'b1, 1'b0, 13'h1000, 19'h0, "t5 oob read");
    txn(1'b0, 1'b1, 13'h1000, 19'h7FFFF, "t5 oob write");
    txn(1'b1, 1'b0, 13'h0000, 19'h0, "t5 read0");

    // Reset during WAIT aborts the write to addr 9.
    @(negedge clk);
    MEM_write = 1'b1; mem_addr = 13'd9; mem_wdata = 19'h12345;
    @(negedge clk);
    check("t6 busy_wait", mem_busy, 1);
    MEM_write = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6 ready", mem_ready, 0);
    check("t6 busy", mem_busy, 0);
    check("t6 rdata reset", mem_rdata, 0);
    last_rd = '0;
    @(negedge clk);
    check("t6 still idle", mem_busy, 0);
    txn(1'b1, 1'b0, 13'd9, 19'h0, "t6 read9");

    for (int n = 0; n < 40; n++) begin
      logic [ADDR_W-1:0] a;
      logic rd, wr;
      int op;
      a  = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(4096, 8191))
                                        : ADDR_W'($urandom_range(0, 15));
      op = $urandom_range(0, 4);
      rd = (op <= 2) || (op == 4);
      wr = (op == 3) || (op == 4);
      txn(rd, wr, a, DATA_W'($urandom), $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
